mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (>=1).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage request qualifier; op sampled only when high.
REQ-006 SHALL have port md_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-007 SHALL have port A  input  32  forwarded rs operand (ALU_RD1 equivalent).
REQ-008 SHALL have port B  input  32  forwarded rt operand (ALU_RD2 equivalent).
REQ-009 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register, for mfhi.
REQ-011 SHALL have port LO  output  32  architectural LO register, for mflo.

Function
REQ-012 SHALL accept an op only when start=1 and busy=0 at a rising edge; otherwise the sample is ignored and no state changes.
REQ-013 SHALL implement two states, IDLE (busy=0) and RUN (busy=1); IDLE->RUN on accepted op 1-4; RUN->IDLE when the down-counter reaches 0.
REQ-014 SHALL, on accepting op 1-4, capture A and B into internal operand registers at that edge; later changes on A/B SHALL not affect the result.
REQ-015 SHALL load the counter with MULT_CYCLES-1 (ops 1-2) or DIV_CYCLES-1 (ops 3-4) at acceptance and decrement once per cycle in RUN.
REQ-016 SHALL hold busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) starting the cycle after the accepting edge.
REQ-017 SHALL update HI/LO at the edge where busy falls; the new values SHALL be visible in the first cycle with busy=0; HI/LO SHALL hold their old values throughout RUN.
REQ-018 mult: {HI,LO} = signed 64-bit product of A and B; multu: unsigned 64-bit product.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-020 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-021 div/divu with B=0 SHALL still run DIV_CYCLES cycles and SHALL leave HI and LO unchanged.
REQ-022 mthi/mtlo accepted in IDLE SHALL write A into HI/LO at that same edge, with busy remaining 0.
REQ-023 start=1 with op 0 or 7 SHALL have no effect.
REQ-024 start=1 during RUN (any op) SHALL be ignored; the stall unit is responsible for holding it in D (stall when D uses MDU and (start or busy)).
REQ-025 A back-to-back op accepted in the cycle busy first reads 0 SHALL observe the just-committed HI/LO (mthi/mtlo) and start a fresh count.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, busy=0, counter=0, HI=0, LO=0, operand and pending-result registers=0.
REQ-027 Reset during RUN SHALL abort the operation; no HI/LO update SHALL occur afterward.
REQ-028 Reset SHALL take priority over a simultaneous start.

Structure
REQ-029 md_op encodings (MD_NONE..MD_MTLO) SHALL live in the shared package with the other pipeline control constants, so that E_CTRL and the stall unit decode from the same source.
REQ-030 The block SHALL be a single module; the product/quotient SHALL be computed combinationally from the captured operands; no sub-module is required.

Verification
REQ-031 reset; start, mult, A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; A changed mid-RUN has no effect.
REQ-033 div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu of the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-034 mthi A=0x12345678 then div A=5, B=0 -> busy 10 cycles; HI stays 0x12345678, LO unchanged.
REQ-035 mult in flight, mtlo issued at cycle 2 of RUN -> ignored; reset at cycle 3 -> busy=0, HI=LO=0 next cycle, no later update.
REQ-036 mult completes; start mtlo A=0xAA in the first cycle with busy=0 -> LO=0xAA next cycle, HI holds the product high word.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared pipeline-control constants for the multiply/divide
//               unit. The md_op encodings live here so that E-stage control
//               and the stall unit decode from one source. This package also
//               holds the MDU state type and the op-class helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // md_op encodings
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_NONE7 = 3'd7;

    // MDU sequencing state: IDLE is busy=0, RUN is busy=1
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // True for the multi-cycle ops (mult, multu, div, divu)
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide ops, which use the longer busy duration
    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit for the E stage.
//               The unit accepts mult/multu/div/divu and holds busy for a
//               fixed number of cycles. At the edge where busy falls it
//               commits the result to HI/LO. mthi/mtlo write HI/LO
//               immediately while the unit is idle.
// Ports       : clk    - sole clock, rising edge
//               reset  - synchronous active-high reset
//               start  - request qualifier; md_op sampled only when high
//               md_op  - operation select (see mult_div_unit_pkg)
//               A, B   - forwarded rs / rt operands
//               busy   - high while a mult/div is in flight
//               HI, LO - architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    md_state_t          r_state;
    md_state_t          w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    // Acceptance looks at the state register directly rather than busy so
    // the decode has no dependency on the FSM output process.
    logic w_accept;
    logic w_done;
    assign w_accept = start && (r_state == ST_IDLE);
    assign w_done   = (r_state == ST_RUN) && (r_count == '0);

    // ------------------------------------------------------------------
    // Result datapath, computed combinationally from captured operands
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide is done on magnitudes, then the signs are applied. This
    // gives 0x80000000 / -1 = 0x80000000 with remainder 0, and it avoids the
    // host-side overflow case of a native signed divide.
    logic        w_sdiv;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    assign w_sdiv     = (r_op == MD_DIV);
    assign w_dvd      = (w_sdiv && r_a[31]) ? (~r_a + 32'd1) : r_a;
    assign w_dvs      = (w_sdiv && r_b[31]) ? (~r_b + 32'd1) : r_b;
    // A zero divisor never commits; substituting 1 keeps the divider defined.
    assign w_dvs_safe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
    assign w_q_mag    = w_dvd / w_dvs_safe;
    assign w_r_mag    = w_dvd % w_dvs_safe;
    assign w_quot     = (w_sdiv && (r_a[31] ^ r_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem      = (w_sdiv && r_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and busy
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && is_muldiv(md_op)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, operand capture and HI/LO update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_accept) begin
            if (is_muldiv(md_op)) begin
                r_op    <= md_op;
                r_a     <= A;
                r_b     <= B;
                r_count <= is_div(md_op) ? c_div_load : c_mult_load;
            end else if (md_op == MD_MTHI) begin
                r_hi <= A;
            end else if (md_op == MD_MTLO) begin
                r_lo <= A;
            end
        end else if (w_done) begin
            case (r_op)
                MD_MULT:  {r_hi, r_lo} <= w_prod_s;
                MD_MULTU: {r_hi, r_lo} <= w_prod_u;
                MD_DIV, MD_DIVU: begin
                    if (r_b != 32'd0) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end else if (r_state == ST_RUN) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit. Inputs change
//               1 time unit after the rising edge, and outputs are sampled at
//               that same point, so each sample shows the state after the
//               preceding edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then drop start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Expect busy for n cycles with HI/LO holding old values, then the result.
    task automatic wait_run(input string tag, input int n,
                            input logic [31:0] old_hi, input logic [31:0] old_lo,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " hold HI"}, HI, old_hi);
            chk({tag, " hold LO"}, LO, old_lo);
            step();
        end
        chk({tag, " busy fall"}, {31'd0, busy}, 32'd0);
        chk({tag, " HI"}, HI, exp_hi);
        chk({tag, " LO"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);

        // signed mult: -2 * 3 = -6
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_run("mult", MULT_CYCLES, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // multu with operand A changed while running
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        A = 32'd0;
        B = 32'd7;
        wait_run("multu", MULT_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFE);

        // div -7 / 2 = -3 rem -1
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_run("div", DIV_CYCLES, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
        issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_run("divu", DIV_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);

        // div 7 / -2 = -3 rem 1
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_run("div neg divisor", DIV_CYCLES, 32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0001, 32'hFFFF_FFFD);

        // overflow case: 0x80000000 / -1
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_run("div ovf", DIV_CYCLES, 32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);

        // mthi writes HI at the accepting edge
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi HI", HI, 32'h1234_5678);
        chk("mthi LO", LO, 32'h8000_0000);

        // divide by zero runs full length and leaves HI/LO alone
        issue(MD_DIV, 32'd5, 32'd0);
        wait_run("div by 0", DIV_CYCLES, 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000);

        // ops 0 and 7 have no effect
        issue(MD_NONE, 32'hDEAD_BEEF, 32'd1);
        chk("op0 busy", {31'd0, busy}, 32'd0);
        issue(MD_NONE7, 32'hDEAD_BEEF, 32'd1);
        chk("op7 busy", {31'd0, busy}, 32'd0);
        chk("op7 HI", HI, 32'h1234_5678);
        chk("op7 LO", LO, 32'h8000_0000);

        // mtlo during RUN is ignored, then reset aborts the mult
        issue(MD_MULT, 32'd3, 32'd4);
        step();
        issue(MD_MTLO, 32'h0000_0055, 32'd0);
        chk("mtlo in run busy", {31'd0, busy}, 32'd1);
        chk("mtlo in run LO", LO, 32'h8000_0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        for (int i = 0; i < MULT_CYCLES + 2; i++) step();
        chk("post abort busy", {31'd0, busy}, 32'd0);
        chk("post abort HI", HI, 32'd0);
        chk("post abort LO", LO, 32'd0);

        // mult then back-to-back mtlo in the first idle cycle
        issue(MD_MULT, 32'h0001_0000, 32'h0003_0000);
        wait_run("mult big", MULT_CYCLES, 32'd0, 32'd0, 32'h0000_0003, 32'h0000_0000);
        issue(MD_MTLO, 32'h0000_00AA, 32'd0);
        chk("b2b mtlo busy", {31'd0, busy}, 32'd0);
        chk("b2b mtlo LO", LO, 32'h0000_00AA);
        chk("b2b mtlo HI", HI, 32'h0000_0003);

        // back-to-back multu starts a fresh count
        issue(MD_MULTU, 32'd2, 32'd3);
        wait_run("b2b multu", MULT_CYCLES, 32'h0000_0003, 32'h0000_00AA, 32'd0, 32'd6);

        // reset wins over a simultaneous start
        reset = 1'b1;
        issue(MD_MULT, 32'd9, 32'd9);
        reset = 1'b0;
        chk("reset prio busy", {31'd0, busy}, 32'd0);
        chk("reset prio LO", LO, 32'd0);
        for (int i = 0; i < MULT_CYCLES + 1; i++) step();
        chk("reset prio later LO", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
